ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It is the outbound counterpart to the PS/2 keyboard receiver and shares the same two open-drain lines. It runs the full inhibit / request-to-send / device-clocked shift / ACK sequence, and asserts `busy` so the receiver can ignore line activity during a transmission.

---
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device byte transmitter: inhibit, request-to-send,
//           device-clocked shift and ACK check. Optional macro
//           PS2_HOST_TX_RETRY_EN retries a failed byte up to twice.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,  // must be >= 2
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_RTS      = 3'd2,
    S_SHIFT    = 3'd3,
    S_ACK      = 3'd4,
    S_WAITIDLE = 3'd5,
    S_DONE     = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, busy_q, ready_q;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             data_meta_q, data_sync_q;
  logic             w_fe, w_fail, w_last_try;

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign w_fe = clk_prev_q & ~clk_sync_q;

`ifdef PS2_HOST_TX_RETRY_EN
  logic [7:0] byte_q, byte_d;
  logic [1:0] tries_q, tries_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_q  <= 8'h00;
      tries_q <= 2'd0;
    end else begin
      byte_q  <= byte_d;
      tries_q <= tries_d;
    end
  end

  assign w_last_try = (tries_q == 2'd2);
`else
  assign w_last_try = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    w_fail    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    byte_d    = byte_q;
    tries_d   = tries_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          state_d   = S_INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          bitcnt_d  = 4'd0;
          shift_d   = {1'b1, ~^tx_data, tx_data};
`ifdef PS2_HOST_TX_RETRY_EN
          byte_d    = tx_data;
          tries_d   = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        // Start bit goes out one cycle before the clock is released.
        if (cnt_q == INH_PRE) data_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d  = S_RTS;
          clk_oe_d = 1'b0;
          cnt_d    = '0;
        end
      end
      S_RTS, S_SHIFT: begin
        if (w_fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          cnt_d     = '0;
          state_d   = (bitcnt_q == 4'd9) ? S_ACK : S_SHIFT;
        end else if (cnt_q == TO_LAST) begin
          w_fail = 1'b1;
        end
      end
      S_ACK: begin
        if (w_fe) begin
          cnt_d = '0;
          if (data_sync_q) w_fail = 1'b1;
          else             state_d = S_WAITIDLE;
        end else if (cnt_q == TO_LAST) begin
          w_fail = 1'b1;
        end
      end
      S_WAITIDLE: begin
        if (clk_sync_q && data_sync_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (w_fe) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          w_fail = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAIL: begin
        state_d = S_IDLE;
`ifdef PS2_HOST_TX_RETRY_EN
        if (!w_last_try) begin
          state_d  = S_INHIBIT;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
          bitcnt_d = 4'd0;
          shift_d  = {1'b1, ~^byte_q, byte_q};
          tries_d  = tries_q + 2'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (w_fail) begin
      state_d   = S_FAIL;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= 10'd0;
      bitcnt_q  <= 4'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= w_fail & w_last_try;
      busy_q    <= (state_d != S_IDLE);
      ready_q   <= (state_d == S_IDLE);
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_host_tx
// Brief   : Self-checking bench for ps2_host_tx with an open-drain device model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 300;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, done, err, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_pin, ps2_data_pin;

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .done(done), .err(err), .busy(busy),
    .ps2_clk_in(ps2_clk_pin), .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Frame as seen on the data line: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // ---------------- per-cycle rule checker ----------------
  int   done_cnt = 0, err_cnt = 0, inh_cnt = 0, acc_cnt = 0;
  int   acc_edge = 0, err_edge = 0, run = 0;
  bit   acc_pend = 0;
  logic prev_done = 0, prev_err = 0, prev_clk_oe = 0, dq1 = 0, dq2 = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      acc_pend = 0; run = 0; prev_done = 0; prev_err = 0;
      prev_clk_oe = 0; dq1 = 0; dq2 = 0;
    end else begin
      check("busy_vs_ready", busy, !tx_ready);
      if (acc_pend) begin
        check("accept_clk_oe", ps2_clk_oe, 1);
        check("accept_ready_low", tx_ready, 0);
      end
      if (done || err) begin
        check("pulse_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        check("pulse_busy", busy, 1);
        check("done_err_exclusive", done & err, 0);
      end
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        done_cnt++;
      end
      if (err) begin
        check("err_one_cycle", prev_err, 0);
        err_cnt++;
        err_edge = cyc;
      end
      if (ps2_clk_oe) begin
        if (!prev_clk_oe) inh_cnt++;
        run++;
      end else if (prev_clk_oe) begin
        check("inhibit_len", run, INH);
        check("data_oe_lead", {dq2, dq1}, 2'b01);
        run = 0;
      end
      dq2 = dq1; dq1 = ps2_data_oe;
      prev_clk_oe = ps2_clk_oe; prev_done = done; prev_err = err;
      acc_pend = tx_valid && tx_ready;
      if (acc_pend) begin
        acc_cnt++;
        acc_edge = cyc + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    tick(1);
    tx_data = b; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0; tx_data = ~b;
  endtask

  task automatic device_xfer(input int n_edges, input bit ack,
                             output logic [10:0] fr, output bit ok);
    int w;
    w = 0; fr = '0; ok = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 3000) begin
      tick(1); w++;
    end
    if (w < 3000) begin
      ok = 1;
      fr[0] = ps2_data_pin;
      tick(4);
      for (int i = 1; i <= n_edges; i++) begin
        if (i == 11 && ack) begin dev_data = 1'b0; tick(4); end
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        if (i <= 10) fr[i] = ps2_data_pin;
        dev_data = 1'b1;
        tick(HALF);
      end
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0, input int bound, input string name);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < bound) begin
      @(negedge clk); w++;
    end
    n_cmp++;
    if (w >= bound) begin
      n_fail++;
      $display("FAIL %s_wait: no done/err within %0d cycles", name, bound);
    end
    tick(2);
  endtask

  task automatic run_ok(input logic [7:0] b, input logic [10:0] lit, input string name);
    logic [10:0] fr;
    bit ok;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_byte(b);
      device_xfer(11, 1'b1, fr, ok);
    join
    wait_outcome(d0, e0, 400, name);
    check({name, "_rts"}, ok, 1);
    check({name, "_frame_model"}, fr, model_frame(b));
    check({name, "_frame_literal"}, fr, lit);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_err_count"}, err_cnt - e0, 0);
    check({name, "_idle"}, {busy, tx_ready}, 2'b01);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: bench did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] fr;
    logic [10:0] mf;
    bit ok;
    int d0, e0, i0, a0, diff, exp_lat;

    rstn = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
    tick(3);
    check("reset_outputs", {tx_ready, done, err, busy, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    rstn = 1'b1;
    tick(3);

    run_ok(8'hED, 11'h7DA, "send_ED");
    run_ok(8'hF4, 11'h5E8, "send_F4");
    run_ok(8'h00, 11'h600, "send_00");

    // Second request during an active transfer must be ignored.
    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    fork
      send_byte(8'hFF);
      device_xfer(11, 1'b1, fr, ok);
      begin tick(60); tx_data = 8'h11; tx_valid = 1'b1; tick(200); tx_valid = 1'b0; end
    join
    wait_outcome(d0, e0, 400, "ignore");
    check("ignore_frame_literal", fr, 11'h7FE);
    check("ignore_frame_model", fr, model_frame(8'hFF));
    check("ignore_accepts", acc_cnt - a0, 1);
    check("ignore_done_count", done_cnt - d0, 1);

    // Device leaves data high on the 11th edge.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    fork
      send_byte(8'h55);
      begin
        for (int a = 0; a < ATTEMPTS; a++) begin
          device_xfer(11, 1'b0, fr, ok);
          check("nack_rts", ok, 1);
        end
      end
    join
    wait_outcome(d0, e0, 400, "nack");
    check("nack_err_count", err_cnt - e0, 1);
    check("nack_done_count", done_cnt - d0, 0);
    check("nack_inhibit_phases", inh_cnt - i0, ATTEMPTS);

    // Device never clocks.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send_byte(8'h5A);
    wait_outcome(d0, e0, ATTEMPTS * (INH + TO + 2) + 50, "timeout");
    exp_lat = ATTEMPTS * (INH + TO) + (ATTEMPTS - 1);
    diff = err_edge - acc_edge;
    check("timeout_latency_in_window", (diff >= exp_lat - 4) && (diff <= exp_lat + 4), 1);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 0);
    check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("timeout_inhibit_phases", inh_cnt - i0, ATTEMPTS);

    // Reset after the fifth device edge.
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_byte(8'h3C);
      device_xfer(5, 1'b0, fr, ok);
    join
    mf = model_frame(8'h3C);
    check("midrst_partial_model", fr[5:0], mf[5:0]);
    check("midrst_partial_literal", fr[5:0], 6'b111000);
    @(posedge clk); #2;
    check("midrst_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    check("midrst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("midrst_ready_busy", {tx_ready, busy}, 2'b10);
    tick(3);
    rstn = 1'b1;
    tick(100);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_idle", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
